// File: rtl/rand_target_gen_if.sv
// Request/response bundle for the random target generator.
// Ports: req/score/seed_load/seed_in flow toward the generator; ran_num, ran_target, valid and busy flow back.
// No backpressure: req is single-shot and is ignored while busy; results are a valid pulse with no ready.
interface rand_target_gen_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] score;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] ran_num;
  logic [3:0]       ran_target;
  logic             valid;
  logic             busy;

  modport master (
    output req, score, seed_load, seed_in,
    input  ran_num, ran_target, valid, busy
  );

  modport slave (
    input  req, score, seed_load, seed_in,
    output ran_num, ran_target, valid, busy
  );
endinterface

// File: rtl/rand_target_gen.sv
// Draws a random value reduced modulo score, then a target index modulo NUM_TARGETS, avoiding the previous target.
// Ports: clk, reset (sync, active-high), bus (slave side of rand_target_gen_if). Latency: k*(2*WIDTH+1)+1 cycles, k = attempts (1..4).
// Backpressure: none; req is taken only in IDLE, and requests arriving while busy are dropped.
module rand_target_gen #(
  parameter int WIDTH       = 32,
  parameter int NUM_TARGETS = 10,
  parameter int SEED        = 2,
  parameter int NO_REPEAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  rand_target_gen_if.slave bus
);

  localparam int              CW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] TAPS   = (WIDTH == 32) ? WIDTH'(32'h8020_0003)
                                                      : WIDTH'(32'h0000_B400);
  localparam logic [WIDTH-1:0] NT_V   = WIDTH'(NUM_TARGETS);
  localparam logic [3:0]       NT_MAX = 4'(NUM_TARGETS - 1);

  typedef enum logic [2:0] {IDLE, MOD_S, MOD_T, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] score_q;
  logic [WIDTH-1:0] dvd;      // dividend, shifted out MSB first
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] num_res;  // MOD_S result of the current attempt
  logic [CW-1:0]    cnt;
  logic [1:0]       retry;
  logic             prev_vld;
  logic [3:0]       prev_tgt;

  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nxt;
  logic             last_bit;
  logic             is_repeat;
  logic             can_retry;
  logic [3:0]       tgt_out;

  // Galois right-shift step
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // One restoring shift-subtract step. A zero divisor always "fits", so the
  // dividend bits just accumulate and the sample comes out unreduced.
  assign divisor  = (state == MOD_T) ? NT_V : score_q;
  assign rem_sh   = {rem, dvd[WIDTH-1]};
  assign rem_nxt  = (rem_sh >= {1'b0, divisor}) ? (rem_sh[WIDTH-1:0] - divisor)
                                                : rem_sh[WIDTH-1:0];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // In CHECK, rem holds the MOD_T result (the candidate target).
  assign is_repeat = (NO_REPEAT != 0) && (NUM_TARGETS > 1) && prev_vld &&
                     (rem[3:0] == prev_tgt);
  assign can_retry = (retry != 2'd3);
  assign tgt_out   = !is_repeat          ? rem[3:0] :
                     (prev_tgt == NT_MAX) ? 4'd0     : prev_tgt + 4'd1;

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req) state_n = MOD_S;
      MOD_S:   if (last_bit) state_n = MOD_T;
      MOD_T:   if (last_bit) state_n = CHECK;
      CHECK:   state_n = (is_repeat && can_retry) ? MOD_S : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr           <= SEED_V;
      score_q        <= '0;
      dvd            <= '0;
      rem            <= '0;
      num_res        <= '0;
      cnt            <= '0;
      retry          <= '0;
      prev_vld       <= 1'b0;
      prev_tgt       <= '0;
      bus.ran_num    <= '0;
      bus.ran_target <= '0;
      bus.valid      <= 1'b0;
    end else begin
      // LFSR runs free; a seed load wins over the step in any state.
      if (bus.seed_load) lfsr <= (bus.seed_in == '0) ? SEED_V : bus.seed_in;
      else               lfsr <= lfsr_step;

      bus.valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req) begin
            dvd     <= lfsr;
            score_q <= bus.score;
            rem     <= '0;
            cnt     <= '0;
          end
        end
        MOD_S: begin
          rem <= rem_nxt;
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // Hand the reduced sample straight to the target reduction.
            num_res <= rem_nxt;
            dvd     <= rem_nxt;
            rem     <= '0;
            cnt     <= '0;
          end
        end
        MOD_T: begin
          rem <= rem_nxt;
          dvd <= dvd << 1;
          cnt <= last_bit ? '0 : cnt + 1'b1;
        end
        CHECK: begin
          if (is_repeat && can_retry) begin
            dvd   <= lfsr;
            rem   <= '0;
            cnt   <= '0;
            retry <= retry + 2'd1;
          end else begin
            // Results are published as DONE is entered so valid lines up with DONE.
            bus.ran_num    <= num_res;
            bus.ran_target <= tgt_out;
            bus.valid      <= 1'b1;
            prev_tgt       <= tgt_out;
            prev_vld       <= 1'b1;
            retry          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rand_target_gen.md
RAND_TARGET_GEN -- requirements
Module: rand_target_gen

Interface
REQ-001 Parameter WIDTH, default 32, sets the LFSR, score and ran_num width; supported values are 16 and 32.
REQ-002 Parameter NUM_TARGETS, default 10, is the number of selectable targets; legal range is 1 to 16.
REQ-003 Parameter SEED, default 2, is the LFSR reset and zero-substitute value; it SHALL be nonzero.
REQ-004 Parameter NO_REPEAT, default 1, enables rejection of a target equal to the previous one.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req, input, 1 bit: requests one random draw; it is sampled only in IDLE.
REQ-008 Port score, input, WIDTH bits: the upper bound (exclusive) for ran_num; it is captured when req is accepted.
REQ-009 Port seed_load, input, 1 bit: loads seed_in into the LFSR.
REQ-010 Port seed_in, input, WIDTH bits: the seed value.
REQ-011 Port ran_num, output, WIDTH bits: the reduced random value, registered.
REQ-012 Port ran_target, output, 4 bits: the target index 0 to NUM_TARGETS-1, registered.
REQ-013 Port valid, output, 1 bit: a one-cycle pulse indicating that ran_num/ran_target were updated.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The LFSR SHALL be a Galois right-shift, stepping every cycle regardless of FSM state: if lsb=1, next = (lfsr>>1)^TAPS; otherwise next = lfsr>>1. TAPS = 0x80200003 for WIDTH=32 and 0xB400 for WIDTH=16.
REQ-016 When seed_load=1, the LFSR SHALL load seed_in (or SEED if seed_in=0) next cycle instead of stepping; this takes priority over stepping, in any state.
REQ-017 The FSM SHALL have the states IDLE, MOD_S, MOD_T, CHECK and DONE.
REQ-018 In IDLE with req=1 (cycle N), the block SHALL capture the current LFSR register value as the sample, capture score, and enter MOD_S.
REQ-019 MOD_S SHALL compute sample mod score by restoring shift-subtract, one bit per cycle, in exactly WIDTH cycles.
REQ-020 If the captured score is 0, MOD_S SHALL still last WIDTH cycles and yield the sample unreduced.
REQ-021 MOD_T SHALL compute (MOD_S result) mod NUM_TARGETS by the same method in exactly WIDTH cycles, then enter CHECK.
REQ-022 CHECK (1 cycle) SHALL decide a repeat as: NO_REPEAT=1, NUM_TARGETS>1, the prev-valid flag set, and the candidate target equal to the previous target.
REQ-023 On a repeat with fewer than 3 retries used, CHECK SHALL resample the current LFSR value, increment the retry count, and return to MOD_S, reusing the captured score.
REQ-024 On a repeat with 3 retries already used, the target SHALL be forced to (previous target+1) mod NUM_TARGETS, while ran_num is the last MOD_S result.
REQ-025 DONE (1 cycle) SHALL register ran_num and ran_target, assert valid, set prev-valid, store the previous target, clear the retry count, and return to IDLE.
REQ-026 Latency from acceptance to valid SHALL be k*(2*WIDTH+1)+1 cycles, where k is the number of attempts (1 to 4); for WIDTH=32 with no retry this is N+66.
REQ-027 A req while busy SHALL be ignored and not queued; score changes while busy SHALL have no effect.
REQ-028 A seed_load while busy SHALL affect only later samples; the in-flight sample is unchanged.
REQ-029 ran_num and ran_target SHALL hold their values between valid pulses.

Reset
REQ-030 While reset=1, the block SHALL set the LFSR to SEED, ran_num=0, ran_target=0, valid=0, busy=0, the state to IDLE, the retry count to 0 and prev-valid to 0.
REQ-031 Reset SHALL take priority over seed_load and req.
REQ-032 Reset mid-operation SHALL abort the draw with no valid pulse.
REQ-033 The first draw after reset SHALL never be rejected.

Verification
REQ-034 Reset then seed_load, seed_in=1, at cycle k; req at k+1 with score=100 -> valid at k+67, ran_num=1, ran_target=1, busy high k+2..k+67.
REQ-035 seed_load, seed_in=0x3E9; next cycle req with score=0 -> ran_num=0x3E9 (1001), ran_target=1.
REQ-036 After REQ-035, req with score=1 accepted at N -> every attempt yields target 0; the first attempt is accepted (prev=1), so ran_target=0 at N+66; a second req with score=1 at M -> three rejections, forced ran_target=1, ran_num=0, valid at M+261.
REQ-037 seed_load, seed_in=0 -> LFSR=SEED (2) next cycle, then 1, then 0x80200003.
REQ-038 Assert reset at N+30 of a draw -> no valid, busy=0 and outputs 0 next cycle; req held during busy is never counted as a second draw.
